// File: rtl/conv_window_sequencer.sv
// Address/control sequencer for a KxK convolution over an IMG_W x IMG_W image.
// Walks windows row-major, one MAC per tap, then holds each result on a valid/ready port.
module conv_window_sequencer #(
  parameter int  IMG_W = 4,
  parameter int  K     = 2,
  localparam int NW    = IMG_W - K + 1,
  localparam int PA_W  = (IMG_W * IMG_W > 1) ? $clog2(IMG_W * IMG_W) : 1,
  localparam int CA_W  = (K * K > 1) ? $clog2(K * K) : 1,
  localparam int OA_W  = (NW * NW > 1) ? $clog2(NW * NW) : 1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            start,
  input  logic            out_ready,
  output logic            busy,
  output logic            done,
  output logic [PA_W-1:0] pix_addr,
  output logic [CA_W-1:0] coef_addr,
  output logic            acc_en,
  output logic            acc_clr,
  output logic            out_valid,
  output logic [OA_W-1:0] out_addr
);

  localparam int RC_W = (NW > 1) ? $clog2(NW) : 1;
  localparam int IJ_W = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

  state_t          state_q, state_d;
  logic [RC_W-1:0] r_q, r_d, c_q, c_d;
  logic [IJ_W-1:0] i_q, i_d, j_q, j_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  // NOTE: every signal written below gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    c_d       = c_q;
    i_d       = i_q;
    j_d       = j_q;
    busy      = 1'b0;
    done      = 1'b0;
    acc_en    = 1'b0;
    acc_clr   = 1'b0;
    out_valid = 1'b0;
    pix_addr  = '0;
    coef_addr = '0;
    out_addr  = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = MAC;
          r_d     = '0;
          c_d     = '0;
          i_d     = '0;
          j_d     = '0;
        end
      end

      MAC: begin
        busy      = 1'b1;
        acc_en    = 1'b1;
        acc_clr   = (i_q == '0) && (j_q == '0);
        pix_addr  = PA_W'((32'(r_q) + 32'(i_q)) * IMG_W + 32'(c_q) + 32'(j_q));
        coef_addr = CA_W'(32'(i_q) * K + 32'(j_q));
        if (j_q == IJ_W'(K - 1)) begin
          j_d = '0;
          if (i_q == IJ_W'(K - 1)) begin
            i_d     = '0;
            state_d = WRITE;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end

      WRITE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_addr  = OA_W'(32'(r_q) * NW + 32'(c_q));
        // Taps already wrapped to 0 on the last MAC; only the window moves here.
        if (out_ready) begin
          if (c_q == RC_W'(NW - 1)) begin
            c_d = '0;
            if (r_q == RC_W'(NW - 1)) begin
              r_d     = '0;
              state_d = DONE;
            end else begin
              r_d     = r_q + 1'b1;
              state_d = MAC;
            end
          end else begin
            c_d     = c_q + 1'b1;
            state_d = MAC;
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for conv_window_sequencer: default (4,2) and (5,3) instances share stimulus.
// Per-cycle traces are compared with a loop-nest frame model plus directed vectors.
module tb_conv_window_sequencer;

  localparam int MAXC = 256;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       acc_en;
    logic       acc_clr;
    logic       out_valid;
    logic [7:0] pix;
    logic [7:0] coef;
    logic [7:0] oaddr;
  } obs_t;

  typedef struct {
    int   scen;
    int   cyc;
    obs_t exp;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RESET, start, out_ready;
  logic       busy_a, done_a, acc_en_a, acc_clr_a, out_valid_a;
  logic [3:0] pix_a;
  logic [1:0] coef_a;
  logic [3:0] oaddr_a;
  logic       busy_b, done_b, acc_en_b, acc_clr_b, out_valid_b;
  logic [4:0] pix_b;
  logic [3:0] coef_b;
  logic [3:0] oaddr_b;

  int n_checks = 0;
  int n_pass   = 0;

  bit   ready_pat [MAXC];
  obs_t cap_a [MAXC];
  obs_t cap_b [MAXC];
  obs_t exp_a [MAXC];
  obs_t exp_b [MAXC];
  obs_t exp_tmp [MAXC];
  vec_t vecs [$];

  always #5 CLK = ~CLK;

  conv_window_sequencer #(.IMG_W(4), .K(2)) dut_a (
    .CLK(CLK), .RESET(RESET), .start(start), .out_ready(out_ready),
    .busy(busy_a), .done(done_a), .pix_addr(pix_a), .coef_addr(coef_a),
    .acc_en(acc_en_a), .acc_clr(acc_clr_a), .out_valid(out_valid_a), .out_addr(oaddr_a)
  );

  conv_window_sequencer #(.IMG_W(5), .K(3)) dut_b (
    .CLK(CLK), .RESET(RESET), .start(start), .out_ready(out_ready),
    .busy(busy_b), .done(done_b), .pix_addr(pix_b), .coef_addr(coef_b),
    .acc_en(acc_en_b), .acc_clr(acc_clr_b), .out_valid(out_valid_b), .out_addr(oaddr_b)
  );

  task automatic check(input string name, input int cyc, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
  endtask

  function automatic obs_t mk(input bit b, input bit d, input bit en, input bit clr,
                              input bit v, input int pix, input int coef, input int oa);
    obs_t o;
    o.busy = b; o.done = d; o.acc_en = en; o.acc_clr = clr; o.out_valid = v;
    o.pix = 8'(pix); o.coef = 8'(coef); o.oaddr = 8'(oa);
    return o;
  endfunction

  function automatic obs_t sample_a();
    return mk(busy_a, done_a, acc_en_a, acc_clr_a, out_valid_a,
              int'(pix_a), int'(coef_a), int'(oaddr_a));
  endfunction

  function automatic obs_t sample_b();
    return mk(busy_b, done_b, acc_en_b, acc_clr_b, out_valid_b,
              int'(pix_b), int'(coef_b), int'(oaddr_b));
  endfunction

  // Frame model: nested loops over windows and taps; a result stays offered
  // until the cycle in which ready_pat is high. A reset ends the frame.
  task automatic build_model(input int img_w, input int k, input int rst_cyc);
    int   nw = img_w - k + 1;
    int   t  = 1;
    bit   acc;
    for (int n = 0; n < MAXC; n++) exp_tmp[n] = '0;
    for (int r = 0; r < nw; r++)
      for (int c = 0; c < nw; c++) begin
        for (int i = 0; i < k; i++)
          for (int j = 0; j < k; j++) begin
            if (t < MAXC)
              exp_tmp[t] = mk(1, 0, 1, (i == 0 && j == 0), 0,
                              (r + i) * img_w + c + j, i * k + j, 0);
            t++;
          end
        do begin
          acc = (t < MAXC) ? ready_pat[t] : 1'b1;
          if (t < MAXC) exp_tmp[t] = mk(1, 0, 0, 0, 1, 0, 0, r * nw + c);
          t++;
        end while (!acc);
      end
    if (t < MAXC) exp_tmp[t] = mk(0, 1, 0, 0, 0, 0, 0, 0);
    if (rst_cyc >= 0)
      for (int n = rst_cyc + 1; n < MAXC; n++) exp_tmp[n] = '0;
  endtask

  // Entered just after a rising edge with both instances idle; cycle 0 carries start.
  task automatic capture(input int start2, input int rst_cyc);
    for (int cyc = 0; cyc < MAXC; cyc++) begin
      start     = (cyc == 0) || (cyc == start2);
      RESET     = (cyc == rst_cyc);
      out_ready = ready_pat[cyc];
      @(negedge CLK);
      cap_a[cyc] = sample_a();
      cap_b[cyc] = sample_b();
      @(posedge CLK);
      #1;
    end
    start = 1'b0;
    RESET = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input int start2, input int rst_cyc);
    int viol;
    build_model(4, 2, rst_cyc);
    exp_a = exp_tmp;
    build_model(5, 3, rst_cyc);
    exp_b = exp_tmp;
    capture(start2, rst_cyc);
    viol = 0;
    for (int n = 0; n < MAXC; n++) begin
      check({tag, "_a"}, n, 64'(cap_a[n]), 64'(exp_a[n]));
      check({tag, "_b"}, n, 64'(cap_b[n]), 64'(exp_b[n]));
      if (cap_a[n].acc_en && cap_a[n].out_valid) viol++;
      if (cap_a[n].acc_clr && !cap_a[n].acc_en) viol++;
      if (cap_a[n].busy && cap_a[n].done) viol++;
      if (cap_b[n].acc_en && cap_b[n].out_valid) viol++;
      if (cap_b[n].acc_clr && !cap_b[n].acc_en) viol++;
      if (cap_b[n].busy && cap_b[n].done) viol++;
    end
    check({tag, "_exclusive"}, 0, 64'(viol), 64'd0);
  endtask

  task automatic apply_vectors(input int scen);
    obs_t act;
    foreach (vecs[v]) begin
      if (vecs[v].scen == scen) begin
        act = (scen == 3) ? cap_b[vecs[v].cyc] : cap_a[vecs[v].cyc];
        check($sformatf("vec_s%0d", scen), vecs[v].cyc, 64'(act), 64'(vecs[v].exp));
      end
    end
  endtask

  initial begin
    // Scenario 0: defaults, ready throughout.
    vecs.push_back('{0, 0,  mk(0, 0, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{0, 1,  mk(1, 0, 1, 1, 0, 0, 0, 0)});
    vecs.push_back('{0, 2,  mk(1, 0, 1, 0, 0, 1, 1, 0)});
    vecs.push_back('{0, 3,  mk(1, 0, 1, 0, 0, 4, 2, 0)});
    vecs.push_back('{0, 4,  mk(1, 0, 1, 0, 0, 5, 3, 0)});
    vecs.push_back('{0, 5,  mk(1, 0, 0, 0, 1, 0, 0, 0)});
    vecs.push_back('{0, 6,  mk(1, 0, 1, 1, 0, 1, 0, 0)});
    vecs.push_back('{0, 7,  mk(1, 0, 1, 0, 0, 2, 1, 0)});
    vecs.push_back('{0, 8,  mk(1, 0, 1, 0, 0, 5, 2, 0)});
    vecs.push_back('{0, 9,  mk(1, 0, 1, 0, 0, 6, 3, 0)});
    vecs.push_back('{0, 41, mk(1, 0, 1, 1, 0, 10, 0, 0)});
    vecs.push_back('{0, 42, mk(1, 0, 1, 0, 0, 11, 1, 0)});
    vecs.push_back('{0, 43, mk(1, 0, 1, 0, 0, 14, 2, 0)});
    vecs.push_back('{0, 44, mk(1, 0, 1, 0, 0, 15, 3, 0)});
    vecs.push_back('{0, 45, mk(1, 0, 0, 0, 1, 0, 0, 8)});
    vecs.push_back('{0, 46, mk(0, 1, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{0, 47, mk(0, 0, 0, 0, 0, 0, 0, 0)});
    // Scenario 1: out_ready low in cycles 15..17.
    for (int n = 15; n <= 18; n++) vecs.push_back('{1, n, mk(1, 0, 0, 0, 1, 0, 0, 2)});
    vecs.push_back('{1, 19, mk(1, 0, 1, 1, 0, 4, 0, 0)});
    vecs.push_back('{1, 46, mk(1, 0, 1, 0, 0, 14, 2, 0)});
    vecs.push_back('{1, 48, mk(1, 0, 0, 0, 1, 0, 0, 8)});
    vecs.push_back('{1, 49, mk(0, 1, 0, 0, 0, 0, 0, 0)});
    // Scenario 2: RESET during cycle 22.
    vecs.push_back('{2, 22, mk(1, 0, 1, 0, 0, 6, 1, 0)});
    vecs.push_back('{2, 23, mk(0, 0, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{2, 46, mk(0, 0, 0, 0, 0, 0, 0, 0)});
    // Scenario 3: IMG_W=5, K=3 last window and done.
    begin
      int p5 [9] = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
      for (int n = 0; n < 9; n++)
        vecs.push_back('{3, 81 + n, mk(1, 0, 1, (n == 0), 0, p5[n], n, 0)});
    end
    vecs.push_back('{3, 90, mk(1, 0, 0, 0, 1, 0, 0, 8)});
    vecs.push_back('{3, 91, mk(0, 1, 0, 0, 0, 0, 0, 0)});

    // Reset held two cycles with start high, then idle without start.
    RESET = 1'b1; start = 1'b1; out_ready = 1'b1;
    repeat (2) begin
      @(posedge CLK); #1;
      check("reset_a", 0, 64'(sample_a()), 64'd0);
      check("reset_b", 0, 64'(sample_b()), 64'd0);
    end
    RESET = 1'b0; start = 1'b0;
    repeat (3) begin
      @(posedge CLK); #1;
      check("idle_a", 0, 64'(sample_a()), 64'd0);
      check("idle_b", 0, 64'(sample_b()), 64'd0);
    end

    for (int n = 0; n < MAXC; n++) ready_pat[n] = 1'b1;
    run_and_check("plain", -1, -1);
    apply_vectors(0);
    apply_vectors(3);

    for (int n = 15; n <= 17; n++) ready_pat[n] = 1'b0;
    run_and_check("stall", -1, -1);
    apply_vectors(1);
    for (int n = 0; n < MAXC; n++) ready_pat[n] = 1'b1;

    run_and_check("restart_ignored", 20, -1);
    run_and_check("midreset", -1, 22);
    apply_vectors(2);
    run_and_check("after_reset", -1, -1);
    apply_vectors(0);

    repeat (4) begin
      for (int n = 0; n < MAXC; n++)
        ready_pat[n] = (n >= 150) ? 1'b1 : ($urandom_range(0, 9) < 7);
      run_and_check("random", int'($urandom_range(2, 40)), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
